seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Time-multiplexed driver for NUM_DIGITS common-anode/cathode 7-segment digits from packed BCD.
//  Successor to the single-digit combinational BCD->7seg decoder: adds digit scanning,
//  per-digit decimal point, leading-zero blanking and tear-free double-buffered loading.
//  Sits between the counter/datapath producing BCD and the board display pins.
// PARAMETERS
//  NUM_DIGITS     4     digits scanned (>=1); digit 0 = least significant = bcd_in[3:0]
//  SCAN_DIV       1000  clk cycles per digit slot (>=2)
//  ACTIVE_LOW_SEG 1     1: segment lit when seg bit = 0
//  ACTIVE_LOW_DIG 1     1: digit enabled when dig_en bit = 0
//  BLANK_LEADING  1     1: suppress leading zeros (digit 0 never suppressed)
// PORTS
//  clk        in   1             single clock, all logic rising-edge
//  rst        in   1             synchronous, active-high reset
//  load_valid in   1             request to load new display value
//  load_ready out  1             pending buffer empty; load accepted when valid&&ready
//  bcd_in     in   4*NUM_DIGITS  packed BCD, digit i = bcd_in[4*i+3:4*i]
//  dp_in      in   NUM_DIGITS    decimal point per digit, 1 = lit
//  seg        out  7             {a,b,c,d,e,f,g}, seg[6]=a, seg[0]=g
//  dp         out  1             decimal point of currently scanned digit
//  dig_en     out  NUM_DIGITS    one-hot (in active polarity) digit enable
//  frame_done out  1             1-cycle pulse, last cycle of digit NUM_DIGITS-1 slot
// BEHAVIOUR
//  Reset: display reg all 4'hF (blank), dp reg 0, pending empty, load_ready=1, slot_cnt=0,
//   dig_idx=0; seg/dp all unlit, dig_en all disabled, frame_done=0 (in configured polarity).
//  Buffers: pending {bcd,dp} captured on valid&&ready; load_ready drops next cycle.
//   Pending copied to display reg in the frame_done cycle; load_ready rises next cycle.
//   Display reg changes only at frame boundaries -> no torn frames.
//  Simultaneous valid&&ready with frame_done: data goes to pending, applied at NEXT frame end.
//  valid while !ready: stall, no capture; source holds data (standard valid/ready).
//  Scan: slot_cnt counts 0..SCAN_DIV-1; at SCAN_DIV-1 wraps to 0 and dig_idx increments,
//   wrapping NUM_DIGITS-1 -> 0. frame_done = (dig_idx==NUM_DIGITS-1)&&(slot_cnt==SCAN_DIV-1).
//  Anti-ghost: in slot_cnt==0 dig_en all disabled; slot_cnt 1..SCAN_DIV-1 enable dig_idx.
//  Outputs registered: seg/dp/dig_en reflect slot state with 1-cycle latency.
//  Decode (active-high lit, a..g): 0=1111110 1=0110000 2=1101101 3=1111001 4=0110011
//   5=1011011 6=1011111 7=1110000 8=1111111 9=1111011; codes 10..15 = all unlit, dp still honoured.
//  ACTIVE_LOW_SEG inverts seg and dp; ACTIVE_LOW_DIG inverts dig_en.
//  Leading-zero blank: digit i>0 unlit (seg and dp) if it and all digits above are code 0
//   and BLANK_LEADING=1; computed from display reg, not pending.
//  Load-to-visible latency <= NUM_DIGITS*SCAN_DIV + 2 cycles.
//  Reset mid-frame/mid-handshake: pending discarded, scan restarts at digit 0, display blank.
// STRUCTURE
//  Package seg7_pkg: SEG_BLANK, SEG_DIGIT[0:9] constants (active-high lit), function
//   bcd_to_seg(4b)->7b.
//  Sub-module seg7_decode: combinational 4b->7b LUT using seg7_pkg; polarity applied in top.
//  Top: pending/display regs + handshake, scan counters, blank mask, output regs.
// TESTING (NUM_DIGITS=4, SCAN_DIV=4, active-low both, BLANK_LEADING=1 unless noted)
//  Reset 3 cycles -> seg=7'b1111111, dp=1, dig_en=4'b1111, load_ready=1, frame_done=0.
//  Load 16'h1234, dp_in=4'b0100 -> after next frame_done: digit0 seg=1001100, digit1
//   0000110, digit2 0010010 dp=0, digit3 1001111; dig_en=1110 then 1101,1011,0111.
//  Load 16'h0070 -> digits 3,2 unlit; digit1 seg=0001111; digit0 seg=0000001.
//  Two loads back-to-back: load_ready=0 after first until the frame_done after it;
//   second held, accepted next cycle, shown one frame later; no frame mixes values.
//  Load 16'h00A5 with BLANK_LEADING=0 -> digit1 seg=1111111, digit0 0100100,
//   digits 3,2 0000001; slot_cnt==0 cycles show dig_en=1111.
//  Assert rst mid-frame with pending full -> next cycle reset values, load_ready=1, blank.

Source files
------------

// File: rtl/seg7_scan_driver_pkg.sv
// Segment constants and BCD-to-segment lookup shared by the scan driver.
// Patterns are active-high lit, ordered {a,b,c,d,e,f,g}.
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   localparam logic [6:0] SEG_DIGIT [10] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
      7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
   };

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
      if (code > 4'd9) return SEG_BLANK;
      return SEG_DIGIT[code];
   endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Load handshake between the BCD producer and the scan driver.
// The producer holds bcd_in/dp_in stable while load_valid && !load_ready.
interface seg7_scan_driver_if #(
   parameter int NUM_DIGITS = 4
);

   logic                      load_valid;
   logic                      load_ready;
   logic [4*NUM_DIGITS-1:0]   bcd_in;
   logic [NUM_DIGITS-1:0]     dp_in;

   modport master (
      output load_valid, bcd_in, dp_in,
      input  load_ready
   );

   modport slave (
      input  load_valid, bcd_in, dp_in,
      output load_ready
   );

endinterface

// File: rtl/seg7_scan_driver_decode.sv
// Combinational BCD digit to active-high segment pattern.
// Codes 10..15 decode to all segments off.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   assign seg = bcd_to_seg(code);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment driver: double-buffered BCD load, digit scan,
// leading-zero blanking and registered, polarity-adjusted pin outputs.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int SCAN_DIV       = 1000,
   parameter bit ACTIVE_LOW_SEG = 1'b1,
   parameter bit ACTIVE_LOW_DIG = 1'b1,
   parameter bit BLANK_LEADING  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   seg7_scan_driver_if.slave     load,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [NUM_DIGITS-1:0] dig_en,
   output logic                  frame_done
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int BW    = 4 * NUM_DIGITS;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0]      slot_cnt;
   logic [IDX_W-1:0]      dig_idx;
   logic                  pend_full;
   logic [BW-1:0]         pend_bcd;
   logic [NUM_DIGITS-1:0] pend_dp;
   logic [BW-1:0]         disp_bcd;
   logic [NUM_DIGITS-1:0] disp_dp;
   logic [NUM_DIGITS-1:0] blank;
   logic [NUM_DIGITS-1:0] onehot;
   logic                  zero_above;
   logic                  take;
   logic [3:0]            cur_code;
   logic [6:0]            cur_seg;
   logic [6:0]            lit_seg;
   logic                  lit_dp;

   assign load.load_ready = !pend_full;
   assign take            = load.load_valid && !pend_full;
   assign frame_done      = (dig_idx == IDX_LAST) && (slot_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_cnt <= '0;
         dig_idx  <= '0;
      end else if (slot_cnt == CNT_LAST) begin
         slot_cnt <= '0;
         dig_idx  <= (dig_idx == IDX_LAST) ? '0 : dig_idx + IDX_W'(1);
      end else begin
         slot_cnt <= slot_cnt + CNT_W'(1);
      end
   end

   // Display only ever changes at a frame boundary, so no frame is torn.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_full <= 1'b0;
         pend_bcd  <= '0;
         pend_dp   <= '0;
         disp_bcd  <= '1;
         disp_dp   <= '0;
      end else if (take) begin
         pend_full <= 1'b1;
         pend_bcd  <= load.bcd_in;
         pend_dp   <= load.dp_in;
      end else if (frame_done && pend_full) begin
         pend_full <= 1'b0;
         disp_bcd  <= pend_bcd;
         disp_dp   <= pend_dp;
      end
   end

   always_comb begin
      blank      = '0;
      zero_above = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above && (disp_bcd[4*i +: 4] == 4'd0);
         blank[i]   = BLANK_LEADING && zero_above;
      end
   end

   assign cur_code = disp_bcd[4*int'(dig_idx) +: 4];

   seg7_decode u_decode (
      .code (cur_code),
      .seg  (cur_seg)
   );

   assign lit_seg = blank[dig_idx] ? SEG_BLANK : cur_seg;
   assign lit_dp  = !blank[dig_idx] && disp_dp[dig_idx];

   // Slot 0 keeps every digit off to hide the segment change (anti-ghost).
   assign onehot = (slot_cnt != '0) ? (NUM_DIGITS'(1) << dig_idx) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         seg    <= {7{ACTIVE_LOW_SEG}};
         dp     <= ACTIVE_LOW_SEG;
         dig_en <= {NUM_DIGITS{ACTIVE_LOW_DIG}};
      end else begin
         seg    <= lit_seg ^ {7{ACTIVE_LOW_SEG}};
         dp     <= lit_dp ^ ACTIVE_LOW_SEG;
         dig_en <= onehot ^ {NUM_DIGITS{ACTIVE_LOW_DIG}};
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (blanking on/off) share stimulus
// and are compared each cycle against a cycle-count based reference model.
module tb_seg7_scan_driver;

   localparam int N = 4;
   localparam int S = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        lv  = 1'b0;
   logic [15:0] bcd = '0;
   logic [3:0]  dpv = '0;

   always #5 clk = ~clk;

   seg7_scan_driver_if #(.NUM_DIGITS(N)) ifa ();
   seg7_scan_driver_if #(.NUM_DIGITS(N)) ifb ();

   assign ifa.load_valid = lv;
   assign ifa.bcd_in     = bcd;
   assign ifa.dp_in      = dpv;
   assign ifb.load_valid = lv;
   assign ifb.bcd_in     = bcd;
   assign ifb.dp_in      = dpv;

   logic [6:0]   seg_a, seg_b;
   logic         dp_a, dp_b, fd_a, fd_b;
   logic [N-1:0] dig_a, dig_b;

   seg7_scan_driver #(
      .NUM_DIGITS(N), .SCAN_DIV(S), .ACTIVE_LOW_SEG(1'b1),
      .ACTIVE_LOW_DIG(1'b1), .BLANK_LEADING(1'b1)
   ) dut_a (
      .clk(clk), .rst(rst), .load(ifa), .seg(seg_a), .dp(dp_a),
      .dig_en(dig_a), .frame_done(fd_a)
   );

   seg7_scan_driver #(
      .NUM_DIGITS(N), .SCAN_DIV(S), .ACTIVE_LOW_SEG(1'b1),
      .ACTIVE_LOW_DIG(1'b1), .BLANK_LEADING(1'b0)
   ) dut_b (
      .clk(clk), .rst(rst), .load(ifb), .seg(seg_b), .dp(dp_b),
      .dig_en(dig_b), .frame_done(fd_b)
   );

   // Reference model: segment table, cycle arithmetic and a pending slot.
   logic [6:0] tbl [10] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
      7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
   };

   int          cyc;
   bit          m_full;
   logic [15:0] m_pbcd, m_disp;
   logic [3:0]  m_pdp, m_ddp;
   int          n_acc;
   int          n_popped;
   logic [27:0] expv;
   logic [27:0] obsv;
   logic [19:0] src_q [$];
   int          n_chk;
   int          n_fail;

   assign obsv = {seg_a, dp_a, dig_a, seg_b, dp_b, dig_b,
                  ifa.load_ready, ifb.load_ready, fd_a, fd_b};

   function automatic logic [11:0] model_out(
      input logic [15:0] disp, input logic [3:0] dps,
      input int digit, input int slot, input bit blank_en
   );
      logic [3:0] code;
      logic [6:0] lit;
      logic       dl;
      logic [3:0] dig;
      code = disp[4*digit +: 4];
      lit  = (code <= 4'd9) ? tbl[code] : 7'b0;
      dl   = dps[digit];
      if (blank_en && digit > 0 && (disp >> (4*digit)) == 16'd0) begin
         lit = 7'b0;
         dl  = 1'b0;
      end
      dig = (slot == 0) ? 4'b0000 : (4'b0001 << digit);
      return {~lit, ~dl, ~dig};
   endfunction

   always @(posedge clk) begin
      int          slot, digit;
      bit          fd, nfd;
      logic [11:0] oa, ob;
      if (rst) begin
         cyc    = 0;
         m_full = 1'b0;
         m_disp = 16'hFFFF;
         m_ddp  = 4'h0;
         expv   = {7'h7F, 1'b1, 4'hF, 7'h7F, 1'b1, 4'hF, 4'b1100};
      end else begin
         slot  = cyc % S;
         digit = (cyc / S) % N;
         fd    = (digit == N-1) && (slot == S-1);
         oa    = model_out(m_disp, m_ddp, digit, slot, 1'b1);
         ob    = model_out(m_disp, m_ddp, digit, slot, 1'b0);
         if (lv && !m_full) begin
            m_full = 1'b1;
            m_pbcd = bcd;
            m_pdp  = dpv;
            n_acc++;
         end else if (fd && m_full) begin
            m_disp = m_pbcd;
            m_ddp  = m_pdp;
            m_full = 1'b0;
         end
         cyc++;
         nfd  = ((cyc % S) == S-1) && (((cyc / S) % N) == N-1);
         expv = {oa, ob, !m_full, !m_full, nfd, nfd};
      end
   end

   // Advance to the next sampling point and update the source side.
   task automatic tick();
      @(negedge clk);
      while (n_popped < n_acc) begin
         void'(src_q.pop_front());
         n_popped++;
      end
      if (src_q.size() > 0) begin
         lv  = 1'b1;
         bcd = src_q[0][19:4];
         dpv = src_q[0][3:0];
      end else begin
         lv = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      n_chk++;
      if (seg_a !== 7'b1111111) begin
         n_fail++; $display("FAIL reset_seg got=%b exp=1111111", seg_a);
      end
      n_chk++;
      if (dp_a !== 1'b1) begin
         n_fail++; $display("FAIL reset_dp got=%b exp=1", dp_a);
      end
      n_chk++;
      if (dig_a !== 4'b1111) begin
         n_fail++; $display("FAIL reset_dig got=%b exp=1111", dig_a);
      end
      n_chk++;
      if (ifa.load_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready got=%b exp=1", ifa.load_ready);
      end
      n_chk++;
      if (fd_a !== 1'b0) begin
         n_fail++; $display("FAIL reset_fd got=%b exp=0", fd_a);
      end
      n_chk++;
      if (obsv !== expv) begin
         n_fail++; $display("FAIL reset_all got=%h exp=%h", obsv, expv);
      end
      rst = 1'b0;
   endtask

   task automatic test_scan(input string name, input logic [15:0] val,
                            input logic [3:0] dps, input bit use_b,
                            input logic [31:0] want [4]);
      logic [7:0] seen [4];
      logic [3:0] pat;
      for (int d = 0; d < 4; d++) seen[d] = 'x;
      src_q.push_back({val, dps});
      repeat (4*N*S) begin
         tick();
         n_chk++;
         if (obsv !== expv) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, obsv, expv);
         end
         for (int d = 0; d < 4; d++) begin
            pat = ~(4'b0001 << d);
            if (!use_b && dig_a == pat) seen[d] = {seg_a, dp_a};
            if (use_b && dig_b == pat)  seen[d] = {seg_b, dp_b};
         end
      end
      for (int d = 0; d < 4; d++) begin
         n_chk++;
         if (seen[d] !== want[d][7:0]) begin
            n_fail++;
            $display("FAIL %s_digit%0d got=%b exp=%b", name, d, seen[d],
                     want[d][7:0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int lo_cnt;
      lo_cnt = 0;
      src_q.push_back({16'h9876, 4'b0001});
      src_q.push_back({16'h0305, 4'b1000});
      repeat (4*N*S) begin
         tick();
         if (ifa.load_ready === 1'b0) lo_cnt++;
         n_chk++;
         if (obsv !== expv) begin
            n_fail++;
            $display("FAIL b2b t=%0t got=%h exp=%h", $time, obsv, expv);
         end
      end
      n_chk++;
      if (src_q.size() != 0 || lo_cnt == 0) begin
         n_fail++;
         $display("FAIL b2b_drain left=%0d ready_low=%0d exp=0,>0",
                  src_q.size(), lo_cnt);
      end
   endtask

   task automatic test_random();
      logic [15:0] v;
      int          budget;
      for (int k = 0; k < 25; k++) begin
         for (int d = 0; d < 4; d++)
            v[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0
                        : 4'($urandom_range(0, 15));
         src_q.push_back({v, 4'($urandom_range(0, 15))});
         budget = 0;
         while ((src_q.size() > 0 || $urandom_range(0, 3) != 0)
                && budget < 3*N*S) begin
            tick();
            budget++;
            n_chk++;
            if (obsv !== expv) begin
               n_fail++;
               $display("FAIL random k=%0d got=%h exp=%h", k, obsv, expv);
            end
         end
         if (src_q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL random_timeout k=%0d left=%0d exp=0", k,
                     src_q.size());
            src_q.delete();
            n_popped = n_acc;
         end
      end
   endtask

   task automatic test_reset_midframe();
      int budget;
      src_q.push_back({16'h4321, 4'b1111});
      src_q.push_back({16'h5555, 4'b0000});
      budget = 0;
      while (src_q.size() > 1 && budget < 2*N*S) begin
         tick();
         budget++;
      end
      repeat (2) tick();
      src_q.delete();
      n_popped = n_acc;
      lv  = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_chk++;
      if (ifa.load_ready !== 1'b1 || seg_a !== 7'h7F || dig_a !== 4'hF) begin
         n_fail++;
         $display("FAIL rst_mid got=%b/%b/%b exp=1/1111111/1111",
                  ifa.load_ready, seg_a, dig_a);
      end
      repeat (2*N*S) begin
         tick();
         n_chk++;
         if (obsv !== expv) begin
            n_fail++;
            $display("FAIL rst_mid_run t=%0t got=%h exp=%h", $time, obsv,
                     expv);
         end
      end
   endtask

   initial begin
      logic [31:0] w [4];
      n_chk    = 0;
      n_fail   = 0;
      n_acc    = 0;
      n_popped = 0;
      test_reset();
      w = '{32'b10011001, 32'b00001101, 32'b00100100, 32'b10011111};
      test_scan("scan_1234", 16'h1234, 4'b0100, 1'b0, w);
      w = '{32'b00000011, 32'b00011111, 32'b11111111, 32'b11111111};
      test_scan("lzb_0070", 16'h0070, 4'b0000, 1'b0, w);
      w = '{32'b01001001, 32'b11111111, 32'b00000011, 32'b00000011};
      test_scan("noblank_00a5", 16'h00A5, 4'b0000, 1'b1, w);
      test_back_to_back();
      test_random();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
